txarq_sched: RTL and testbench

Per-LT_ADDR transmit ARQ scheduler for the ACL payload path. It tracks, for each of 8 logical transports, whether a new payload is queued, sent-and-unacknowledged, or idle, and drives `sendnewpy` and `tx_seqn` toward the payload buffer controller, which toggles its ping-pong buffer on `sendnewpy & tx_packet_st_p`. It also applies received FLOW, runs a per-LT flush timeout, and raises the new-payload and flush interrupts to the MCU.

---
 rtl/txarq_pkg.sv | 28 ++
 rtl/txarq_sched_if.sv | 37 +++
 rtl/txarq_ltslot.sv | 108 ++++++++++
 rtl/txarq_sched.sv | 83 ++++++++
 tb/tb_txarq_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/txarq_pkg.sv
// Shared types and constants for the per-LT_ADDR transmit ARQ scheduler.
package txarq_pkg;

  localparam int unsigned NUM_LT  = 8;
  localparam int unsigned FTW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    WAIT = 2'b10
  } lt_state_e;

  // Lowest-numbered set bit; used when several LTs expire in the same cycle.
  function automatic logic [2:0] lowest_set(input logic [NUM_LT-1:0] v);
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LT; i++) begin
      if (v[i] && !found) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/txarq_sched_if.sv
// Scheduler bus: MCU, tx-timing and header-decoder strobes in, ARQ controls and interrupts out.
interface txarq_sched_if
  import txarq_pkg::*;
#(
  parameter int unsigned FTW = FTW_DEF
) ();
  logic           ms_tslot_p;
  logic           tx_packet_st_p;
  logic [2:0]     lt_addr;
  logic           regi_txready_p;
  logic           regi_flush_p;
  logic [2:0]     regi_lt_addr;
  logic [FTW-1:0] regi_flushto;
  logic           dec_hdr_p;
  logic [2:0]     dec_lt_addr;
  logic           dec_arqn;
  logic           dec_flow;
  logic           sendnewpy;
  logic           tx_seqn;
  logic           tx_flowok;
  logic [7:0]     lt_busy;
  logic           newpy_int;
  logic           flush_int;
  logic [2:0]     int_lt_addr;

  modport master (
    output ms_tslot_p, tx_packet_st_p, lt_addr, regi_txready_p, regi_flush_p,
           regi_lt_addr, regi_flushto, dec_hdr_p, dec_lt_addr, dec_arqn, dec_flow,
    input  sendnewpy, tx_seqn, tx_flowok, lt_busy, newpy_int, flush_int, int_lt_addr
  );

  modport slave (
    input  ms_tslot_p, tx_packet_st_p, lt_addr, regi_txready_p, regi_flush_p,
           regi_lt_addr, regi_flushto, dec_hdr_p, dec_lt_addr, dec_arqn, dec_flow,
    output sendnewpy, tx_seqn, tx_flowok, lt_busy, newpy_int, flush_int, int_lt_addr
  );
endinterface

// File: rtl/txarq_ltslot.sv
// One logical transport's ARQ state: IDLE/PEND/WAIT, SEQN, queued, flow_stop, flush counter.
// Flush counter and expiry exist only when TXARQ_FLUSH_EN is defined.
module txarq_ltslot
  import txarq_pkg::*;
#(
  parameter int unsigned FTW = FTW_DEF
) (
  input  logic           clk_6M,
  input  logic           rstz,
  input  logic           ready_hit_i,
  input  logic           flush_hit_i,
  input  logic           tx_hit_i,
  input  logic           hdr_hit_i,
  input  logic           arqn_i,
  input  logic           flow_i,
  input  logic           tslot_i,
  input  logic [FTW-1:0] flushto_i,
  output lt_state_e      state_o,
  output logic           seqn_o,
  output logic           flow_stop_o,
  output logic           ack_evt_o,
  output logic           flush_evt_o
);

  lt_state_e state_q, state_d;
  logic      seqn_q, seqn_d;
  logic      queued_q, queued_d;
  logic      flow_stop_q, flow_stop_d;
  logic      expire;

`ifdef TXARQ_FLUSH_EN
  logic [FTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_flush_inputs;
  assign unused_flush_inputs = ^{tslot_i, flushto_i};
`endif

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q     <= IDLE;
      seqn_q      <= 1'b0;
      queued_q    <= 1'b0;
      flow_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seqn_q      <= seqn_d;
      queued_q    <= queued_d;
      flow_stop_q <= flow_stop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seqn_d      = seqn_q;
    queued_d    = queued_q;
    flow_stop_d = hdr_hit_i ? ~flow_i : flow_stop_q;
    ack_evt_o   = 1'b0;
    flush_evt_o = 1'b0;
    expire      = 1'b0;
`ifdef TXARQ_FLUSH_EN
    cnt_d = cnt_q;
    if (state_q == WAIT && tslot_i && flushto_i != '0 && cnt_q != '0) begin
      cnt_d  = cnt_q - 1'b1;
      expire = (cnt_q == FTW'(1));
    end
`endif
    // Priority: MCU flush > ACK > expiry > tx; a coincident ready always lands in PEND.
    if (flush_hit_i) begin
      state_d     = ready_hit_i ? PEND : IDLE;
      queued_d    = 1'b0;
      flush_evt_o = 1'b1;
    end else if (state_q == WAIT && hdr_hit_i && arqn_i) begin
      state_d   = (queued_q || ready_hit_i) ? PEND : IDLE;
      queued_d  = 1'b0;
      ack_evt_o = 1'b1;
    end else if (expire) begin
      state_d     = (queued_q || ready_hit_i) ? PEND : IDLE;
      queued_d    = 1'b0;
      flush_evt_o = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (ready_hit_i) state_d = PEND;
        PEND: begin
          if (ready_hit_i) queued_d = 1'b1;
          if (tx_hit_i) begin
            state_d = WAIT;
            seqn_d  = ~seqn_q;
`ifdef TXARQ_FLUSH_EN
            cnt_d   = flushto_i;
`endif
          end
        end
        WAIT:    if (ready_hit_i) queued_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  assign state_o     = state_q;
  assign seqn_o      = seqn_q;
  assign flow_stop_o = flow_stop_q;

endmodule

// File: rtl/txarq_sched.sv
// Per-LT_ADDR transmit ARQ scheduler: LT decode, eight txarq_ltslot instances, output mux, IRQs.
// Optional flush timeout is enabled with the TXARQ_FLUSH_EN macro.
module txarq_sched
  import txarq_pkg::*;
#(
  parameter int unsigned FTW = FTW_DEF
) (
  input logic         clk_6M,
  input logic         rstz,
  txarq_sched_if.slave bus
);

  logic [NUM_LT-1:0] ready_hit, flush_hit, tx_hit, hdr_hit;
  logic [NUM_LT-1:0] seqn, flow_stop, ack_evt, flush_evt;
  lt_state_e         st [NUM_LT];

  logic       newpy_int_q, newpy_int_d;
  logic       flush_int_q, flush_int_d;
  logic [2:0] int_lt_addr_q, int_lt_addr_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_LT; i++) begin
      ready_hit[i] = bus.regi_txready_p && (bus.regi_lt_addr == 3'(i));
      flush_hit[i] = bus.regi_flush_p   && (bus.regi_lt_addr == 3'(i));
      tx_hit[i]    = bus.tx_packet_st_p && (bus.lt_addr == 3'(i));
      hdr_hit[i]   = bus.dec_hdr_p      && (bus.dec_lt_addr == 3'(i));
    end
  end

  for (genvar g = 0; g < NUM_LT; g++) begin : g_lt
    txarq_ltslot #(.FTW(FTW)) u_slot (
      .clk_6M      (clk_6M),
      .rstz        (rstz),
      .ready_hit_i (ready_hit[g]),
      .flush_hit_i (flush_hit[g]),
      .tx_hit_i    (tx_hit[g]),
      .hdr_hit_i   (hdr_hit[g]),
      .arqn_i      (bus.dec_arqn),
      .flow_i      (bus.dec_flow),
      .tslot_i     (bus.ms_tslot_p),
      .flushto_i   (bus.regi_flushto),
      .state_o     (st[g]),
      .seqn_o      (seqn[g]),
      .flow_stop_o (flow_stop[g]),
      .ack_evt_o   (ack_evt[g]),
      .flush_evt_o (flush_evt[g])
    );
  end

  // MCU-port LT wins int_lt_addr, then the decoder LT, then any expiring LT.
  always_comb begin
    newpy_int_d   = |ack_evt;
    flush_int_d   = |flush_evt;
    int_lt_addr_d = int_lt_addr_q;
    if (bus.regi_flush_p)  int_lt_addr_d = bus.regi_lt_addr;
    else if (|ack_evt)     int_lt_addr_d = bus.dec_lt_addr;
    else if (|flush_evt)   int_lt_addr_d = lowest_set(flush_evt);
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      newpy_int_q   <= 1'b0;
      flush_int_q   <= 1'b0;
      int_lt_addr_q <= '0;
    end else begin
      newpy_int_q   <= newpy_int_d;
      flush_int_q   <= flush_int_d;
      int_lt_addr_q <= int_lt_addr_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_LT; i++) bus.lt_busy[i] = (st[i] != IDLE);
  end

  assign bus.sendnewpy   = (st[bus.lt_addr] == PEND);
  assign bus.tx_seqn     = seqn[bus.lt_addr] ^ bus.sendnewpy;
  assign bus.tx_flowok   = ~flow_stop[bus.lt_addr];
  assign bus.newpy_int   = newpy_int_q;
  assign bus.flush_int   = flush_int_q;
  assign bus.int_lt_addr = int_lt_addr_q;

endmodule

// File: tb/tb_txarq_sched.sv
// Directed bench for txarq_sched: interrupt scoreboard plus level checks on the ARQ outputs.
module tb_txarq_sched;
  import txarq_pkg::*;

  typedef struct packed {
    logic       newpy;
    logic       flush;
    logic [2:0] addr;
  } irq_t;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  irq_t exp_q[$];

  txarq_sched_if #(.FTW(16)) bus ();

  txarq_sched #(.FTW(16)) u_dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic np, input logic fl, input logic [2:0] a);
    irq_t e;
    e.newpy = np;
    e.flush = fl;
    e.addr  = a;
    exp_q.push_back(e);
  endtask

  // Interrupt monitor: every pulse must match the next expected entry.
  initial begin
    irq_t e, got;
    forever begin
      @(negedge clk_6M);
      if (bus.newpy_int || bus.flush_int) begin
        got = '{newpy: bus.newpy_int, flush: bus.flush_int, addr: bus.int_lt_addr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL irq_unexpected: got newpy=%0b flush=%0b addr=%0d, required none",
                   got.newpy, got.flush, got.addr);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL irq_match: got newpy=%0b flush=%0b addr=%0d, required newpy=%0b flush=%0b addr=%0d",
                     got.newpy, got.flush, got.addr, e.newpy, e.flush, e.addr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    bus.ms_tslot_p = 0; bus.tx_packet_st_p = 0; bus.lt_addr = 0;
    bus.regi_txready_p = 0; bus.regi_flush_p = 0; bus.regi_lt_addr = 0;
    bus.regi_flushto = 0; bus.dec_hdr_p = 0; bus.dec_lt_addr = 0;
    bus.dec_arqn = 0; bus.dec_flow = 1;
    repeat (3) @(posedge clk_6M);
    #1 rstz = 1'b1;

    @(negedge clk_6M);
    chk("rst_sendnewpy", 8'(bus.sendnewpy), 8'h00);
    chk("rst_tx_seqn",   8'(bus.tx_seqn),   8'h00);
    chk("rst_tx_flowok", 8'(bus.tx_flowok), 8'h01);
    chk("rst_lt_busy",   bus.lt_busy,       8'h00);
    chk("rst_int_addr",  8'(bus.int_lt_addr), 8'h00);
    tick();

    // First payload on LT2 goes out new with SEQN=1
    bus.regi_lt_addr = 2; bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    bus.lt_addr = 2; bus.tx_packet_st_p = 1;
    @(negedge clk_6M);
    chk("t1_sendnewpy", 8'(bus.sendnewpy), 8'h01);
    chk("t1_tx_seqn",   8'(bus.tx_seqn),   8'h01);
    tick(); bus.tx_packet_st_p = 0;
    @(negedge clk_6M);
    chk("t1_lt_busy", bus.lt_busy, 8'h04);
    tick();

    // NAK then retransmit, then ACK
    bus.dec_lt_addr = 2; bus.dec_arqn = 0; bus.dec_flow = 1; bus.dec_hdr_p = 1;
    tick(); bus.dec_hdr_p = 0;
    bus.lt_addr = 2; bus.tx_packet_st_p = 1;
    @(negedge clk_6M);
    chk("t2_retx_sendnewpy", 8'(bus.sendnewpy), 8'h00);
    chk("t2_retx_tx_seqn",   8'(bus.tx_seqn),   8'h01);
    chk("t2_retx_busy",      bus.lt_busy,       8'h04);
    tick(); bus.tx_packet_st_p = 0;
    bus.dec_arqn = 1; bus.dec_hdr_p = 1; push(1'b1, 1'b0, 3'd2);
    tick(); bus.dec_hdr_p = 0;
    @(negedge clk_6M);
    chk("t2_ack_busy", bus.lt_busy, 8'h00);
    tick();

    // Flush timeout of 3 slots on LT5
    bus.regi_flushto = 16'd3;
    bus.regi_lt_addr = 5; bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    bus.lt_addr = 5; bus.tx_packet_st_p = 1;
    @(negedge clk_6M);
    chk("t3_first_tx_seqn", 8'(bus.tx_seqn), 8'h01);
    tick(); bus.tx_packet_st_p = 0;
    for (int n = 0; n < 2; n++) begin
      bus.ms_tslot_p = 1; tick(); bus.ms_tslot_p = 0; tick();
    end
`ifdef TXARQ_FLUSH_EN
    push(1'b0, 1'b1, 3'd5);
`endif
    bus.ms_tslot_p = 1; tick(); bus.ms_tslot_p = 0;
    @(negedge clk_6M);
`ifdef TXARQ_FLUSH_EN
    chk("t3_expired_busy", bus.lt_busy, 8'h00);
    tick();
`else
    chk("t3_noexpiry_busy", bus.lt_busy, 8'h20);
    tick();
    bus.regi_lt_addr = 5; bus.regi_flush_p = 1; push(1'b0, 1'b1, 3'd5);
    tick(); bus.regi_flush_p = 0;
`endif
    bus.regi_lt_addr = 5; bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    bus.lt_addr = 5; bus.tx_packet_st_p = 1;
    @(negedge clk_6M);
    chk("t3_next_sendnewpy", 8'(bus.sendnewpy), 8'h01);
    chk("t3_next_tx_seqn",   8'(bus.tx_seqn),   8'h00);
    tick(); bus.tx_packet_st_p = 0;
    bus.regi_lt_addr = 5; bus.regi_flush_p = 1; push(1'b0, 1'b1, 3'd5);
    tick(); bus.regi_flush_p = 0;

    // LT1 queued; ACK coincides with counter expiry
    bus.regi_lt_addr = 1; bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    bus.lt_addr = 1; bus.tx_packet_st_p = 1; tick(); bus.tx_packet_st_p = 0;
    bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    for (int n = 0; n < 2; n++) begin
      bus.ms_tslot_p = 1; tick(); bus.ms_tslot_p = 0; tick();
    end
    bus.ms_tslot_p = 1; bus.dec_lt_addr = 1; bus.dec_arqn = 1; bus.dec_hdr_p = 1;
    push(1'b1, 1'b0, 3'd1);
    tick(); bus.ms_tslot_p = 0; bus.dec_hdr_p = 0;
    @(negedge clk_6M);
    chk("t4_pend_busy", bus.lt_busy, 8'h02);
    tick();
    bus.lt_addr = 1; bus.tx_packet_st_p = 1;
    @(negedge clk_6M);
    chk("t4_sendnewpy", 8'(bus.sendnewpy), 8'h01);
    chk("t4_tx_seqn",   8'(bus.tx_seqn),   8'h00);
    tick(); bus.tx_packet_st_p = 0;
    bus.dec_lt_addr = 1; bus.dec_arqn = 1; bus.dec_hdr_p = 1; push(1'b1, 1'b0, 3'd1);
    tick(); bus.dec_hdr_p = 0;
    bus.regi_flushto = 16'd0;

    // MCU flush on LT7 and ACK on LT2 in the same cycle
    bus.regi_lt_addr = 2; bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    bus.lt_addr = 2; bus.tx_packet_st_p = 1; tick(); bus.tx_packet_st_p = 0;
    bus.regi_lt_addr = 7; bus.regi_flush_p = 1;
    bus.dec_lt_addr = 2; bus.dec_arqn = 1; bus.dec_hdr_p = 1;
    push(1'b1, 1'b1, 3'd7);
    tick(); bus.regi_flush_p = 0; bus.dec_hdr_p = 0;
    @(negedge clk_6M);
    chk("t5_busy", bus.lt_busy, 8'h00);
    tick();

    // Remote FLOW per LT
    bus.dec_lt_addr = 3; bus.dec_arqn = 0; bus.dec_flow = 0; bus.dec_hdr_p = 1;
    tick(); bus.dec_hdr_p = 0;
    bus.lt_addr = 3;
    @(negedge clk_6M);
    chk("t6_flow_stop_lt3", 8'(bus.tx_flowok), 8'h00);
    tick();
    bus.lt_addr = 4;
    @(negedge clk_6M);
    chk("t6_flow_go_lt4", 8'(bus.tx_flowok), 8'h01);
    tick();
    bus.dec_lt_addr = 3; bus.dec_flow = 1; bus.dec_hdr_p = 1;
    tick(); bus.dec_hdr_p = 0;
    bus.lt_addr = 3;
    @(negedge clk_6M);
    chk("t6_flow_restored_lt3", 8'(bus.tx_flowok), 8'h01);
    tick();

    // Asynchronous reset while LT6 waits for ACK
    bus.regi_lt_addr = 6; bus.regi_txready_p = 1; tick(); bus.regi_txready_p = 0;
    bus.lt_addr = 6; bus.tx_packet_st_p = 1; tick(); bus.tx_packet_st_p = 0;
    bus.dec_lt_addr = 6; bus.dec_arqn = 0; bus.dec_flow = 0; bus.dec_hdr_p = 1;
    tick(); bus.dec_hdr_p = 0; bus.dec_flow = 1;
    @(negedge clk_6M);
    chk("t7_pre_busy",   bus.lt_busy,        8'h40);
    chk("t7_pre_flowok", 8'(bus.tx_flowok),  8'h00);
    chk("t7_pre_seqn",   8'(bus.tx_seqn),    8'h01);
    #2 rstz = 1'b0;
    #1;
    chk("t7_rst_sendnewpy", 8'(bus.sendnewpy),   8'h00);
    chk("t7_rst_tx_seqn",   8'(bus.tx_seqn),     8'h00);
    chk("t7_rst_tx_flowok", 8'(bus.tx_flowok),   8'h01);
    chk("t7_rst_lt_busy",   bus.lt_busy,         8'h00);
    chk("t7_rst_newpy",     8'(bus.newpy_int),   8'h00);
    chk("t7_rst_flush",     8'(bus.flush_int),   8'h00);
    chk("t7_rst_int_addr",  8'(bus.int_lt_addr), 8'h00);
    repeat (2) tick();
    rstz = 1'b1;
    repeat (4) tick();

    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
